alu_shift_issue: RTL and testbench

ALU_SHIFT_ISSUE -- requirements
Module: alu_shift_issue

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shift_issue_if.sv | 26 ++
 rtl/alu_issue_fifo.sv | 42 ++++
 rtl/alu_shift_issue.sv | 176 +++++++++++++++++
 tb/tb_alu_shift_issue.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode constants, FSM state type and queue-entry layout
package alu_pkg;

    localparam logic [2:0] FUNCT_SHL    = 3'b000;
    localparam logic [2:0] FUNCT_SHR    = 3'b001;
    localparam logic [2:0] FUNCT_ASHR   = 3'b010;
    localparam logic [2:0] FUNCT_FSHIFT = 3'b011;

    // Queue entries carry the widest supported tag; the top narrows it to TAG_W.
    localparam int QTAG_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAITF = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]       a;
        logic [31:0]       b;
        logic [2:0]        funct;
        logic [QTAG_W-1:0] tag;
    } q_entry_t;

endpackage

// File: rtl/alu_shift_issue_if.sv
// rtl/alu_shift_issue_if.sv - operation and result handshake bundle
interface alu_shift_issue_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_funct;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_funct, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_funct, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/alu_issue_fifo.sv
// rtl/alu_issue_fifo.sv - power-of-two operation queue with head look-ahead
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  q_entry_t push_data,
    input  logic     pop,
    output q_entry_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    q_entry_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; the head is only consumed when the queue is non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_shift_issue.sv
// rtl/alu_shift_issue.sv - queued shift-unit issue stage; ALU_SHIFT_ISSUE_TIMEOUT_EN adds a funnel-wait watchdog
module alu_shift_issue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TMO_CYC = 40
) (
    input  logic        clk,
    input  logic        reset,
    alu_shift_issue_if.slave io,
    output logic        sh_valid_i,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic [2:0]  sh_funct,
    input  logic [31:0] sh_result,
    input  logic        sh_valid_o,
    output logic        busy,
    output logic        err
);
    state_t            state_q, state_d;
    q_entry_t          push_data, head;
    logic              full, empty, push, pop, issue, capture;
    logic              first_q, skip_q, byp_q;
    logic [31:0]       byp_data_q, cap_data;
    logic [QTAG_W-1:0] tag_q;
    logic              out_valid_q;
    logic [31:0]       out_result_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              out_free, head_fshift, head_zero;
    logic              unused_tag_bits;

    assign push      = io.in_valid && !full;
    assign push_data = '{a: io.in_a, b: io.in_b, funct: io.in_funct, tag: QTAG_W'(io.in_tag)};

    alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign out_free    = !out_valid_q || io.out_ready;
    assign head_fshift = (head.funct == FUNCT_FSHIFT);
    assign head_zero   = (head.b[4:0] == 5'd0);

`ifdef ALU_SHIFT_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_hit, tmo_fire;
    assign tmo_hit = (state_q == WAITF) && (tmo_cnt_q == CNT_W'(TMO_CYC - 1));
`else
    localparam int tmo_cyc_unused = TMO_CYC;
`endif

    // Next state: pop when the result slot will be free, then wait for the one in-flight op.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        issue    = 1'b0;
        capture  = 1'b0;
        cap_data = '0;
`ifdef ALU_SHIFT_ISSUE_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!empty && out_free) begin
                    pop     = 1'b1;
                    issue   = !(head_fshift && head_zero);
                    state_d = (head_fshift && !head_zero) ? WAITF : WAIT1;
                end
            end
            WAIT1: begin
                if (!first_q) begin
                    capture  = 1'b1;
                    cap_data = byp_q ? byp_data_q : sh_result;
                    state_d  = IDLE;
                end
            end
            WAITF: begin
                if (!first_q && !skip_q && sh_valid_o) begin
                    capture  = 1'b1;
                    cap_data = sh_result;
                    state_d  = IDLE;
                end
`ifdef ALU_SHIFT_ISSUE_TIMEOUT_EN
                else if (tmo_hit) begin
                    capture  = 1'b1;
                    cap_data = 32'hDEAD_BEEF;
                    tmo_fire = 1'b1;
                    state_d  = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue register and in-flight bookkeeping; first_q marks the issue cycle, skip_q the one after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            first_q    <= 1'b0;
            skip_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            tag_q      <= '0;
            sh_valid_i <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_funct   <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= pop;
            sh_valid_i <= issue;
            if (issue) begin
                sh_a     <= head.a;
                sh_b     <= head.b;
                sh_funct <= head.funct;
            end
            if (pop) begin
                byp_q      <= !issue;
                byp_data_q <= head.a;
                tag_q      <= head.tag;
                skip_q     <= 1'b1;
            end else if (state_q == WAITF && !first_q) begin
                skip_q <= 1'b0;
            end
        end
    end

    // Result register: holds until drained; a capture may replace a word being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else if (capture) begin
            out_valid_q  <= 1'b1;
            out_result_q <= cap_data;
            out_tag_q    <= tag_q[TAG_W-1:0];
        end else if (out_valid_q && io.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

`ifdef ALU_SHIFT_ISSUE_TIMEOUT_EN
    // Watchdog: counts cycles spent waiting on the funnel shifter; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            err       <= 1'b0;
        end else begin
            if (pop)                   tmo_cnt_q <= '0;
            else if (state_q == WAITF) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            if (tmo_fire)              err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign unused_tag_bits = ^tag_q;

    assign io.in_ready   = !full;
    assign io.out_valid  = out_valid_q;
    assign io.out_result = out_result_q;
    assign io.out_tag    = out_tag_q;
    assign busy          = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_shift_issue.sv
// tb/tb_alu_shift_issue.sv - directed self-checking bench for alu_shift_issue
module tb_alu_shift_issue;
    import alu_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TMO_CYC = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sh_valid_i;
    logic [31:0] sh_a, sh_b;
    logic [2:0]  sh_funct;
    logic [31:0] sh_result = '0;
    logic        sh_valid_o = 1'b0;
    logic        busy, err;

    int total = 0;
    int bad   = 0;

    alu_shift_issue_if #(.TAG_W(TAG_W)) io();

    alu_shift_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TMO_CYC(TMO_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .io         (io),
        .sh_valid_i (sh_valid_i),
        .sh_a       (sh_a),
        .sh_b       (sh_b),
        .sh_funct   (sh_funct),
        .sh_result  (sh_result),
        .sh_valid_o (sh_valid_o),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Shift-unit model: plain shifts answer next cycle; funnel answers after b cycles and leaves valid high.
    int          m_cnt = 0;
    logic [31:0] m_a = '0;
    logic [4:0]  m_b = '0;
    logic        m_hold = 1'b0;

    function automatic logic [31:0] rotl(input logic [31:0] a, input logic [4:0] b);
        return (a << b) | (a >> (6'd32 - {1'b0, b}));
    endfunction

    always @(posedge clk) begin
        if (sh_valid_i) begin
            if (sh_funct == FUNCT_FSHIFT) begin
                m_cnt <= int'(sh_b[4:0]);
                m_a   <= sh_a;
                m_b   <= sh_b[4:0];
            end else begin
                case (sh_funct)
                    FUNCT_SHL:  sh_result <= sh_a << sh_b[4:0];
                    FUNCT_SHR:  sh_result <= sh_a >> sh_b[4:0];
                    FUNCT_ASHR: sh_result <= $signed(sh_a) >>> sh_b[4:0];
                    default:    sh_result <= sh_a;
                endcase
            end
        end else if (m_cnt == 1) begin
            m_cnt <= 0;
            if (!m_hold) begin
                sh_valid_o <= 1'b1;
                sh_result  <= rotl(m_a, m_b);
            end
        end else if (m_cnt > 1) begin
            m_cnt      <= m_cnt - 1;
            sh_valid_o <= 1'b0;
        end
    end

    // Result monitor: records every completed output transfer.
    logic [31:0] res_q[$];
    logic [31:0] rtag_q[$];
    int          iss_q[$];
    int          issue_cnt = 0;

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (sh_valid_i) issue_cnt++;
            if (io.out_valid && io.out_ready) begin
                res_q.push_back(io.out_result);
                rtag_q.push_back(32'(io.out_tag));
                iss_q.push_back(issue_cnt);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f, input logic [3:0] t);
        int w;
        w = 0;
        while (!io.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!io.in_ready) check("push_ready", 32'(io.in_ready), 32'd1);
        io.in_valid = 1'b1;
        io.in_a     = a;
        io.in_b     = b;
        io.in_funct = f;
        io.in_tag   = t;
        @(posedge clk);
        @(negedge clk);
        io.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [3:0]  t;
        logic [31:0] r;
        int          lat;
        int          pulses;
    } vec_t;

    vec_t vecs[8];

    task automatic run_one(input vec_t v, input int idx);
        int lat, pulses;
        lat = 0;
        pulses = 0;
        push_op(v.a, v.b, v.f, v.t);
        forever begin
            if (sh_valid_i) pulses++;
            if (io.out_valid || lat >= 200) break;
            @(negedge clk);
            lat++;
        end
        check($sformatf("lat_%0d", idx), 32'(lat), 32'(v.lat));
        check($sformatf("pulses_%0d", idx), 32'(pulses), 32'(v.pulses));
        check($sformatf("result_%0d", idx), io.out_result, v.r);
        check($sformatf("tag_%0d", idx), 32'(io.out_tag), 32'(v.t));
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, w;
        logic ov, iv;

        vecs[0] = '{32'h0000_0001, 32'd5,  FUNCT_SHL,    4'h3, 32'h0000_0020, 3,  1};
        vecs[1] = '{32'h0000_00F0, 32'd4,  FUNCT_SHR,    4'h1, 32'h0000_000F, 3,  1};
        vecs[2] = '{32'h8000_0000, 32'd4,  FUNCT_ASHR,   4'h2, 32'hF800_0000, 3,  1};
        vecs[3] = '{32'hCAFE_F00D, 32'd7,  3'b101,       4'h4, 32'hCAFE_F00D, 3,  1};
        vecs[4] = '{32'h8000_0001, 32'd4,  FUNCT_FSHIFT, 4'h5, 32'h0000_0018, 7,  1};
        vecs[5] = '{32'h1234_5678, 32'd0,  FUNCT_FSHIFT, 4'h6, 32'h1234_5678, 3,  0};
        vecs[6] = '{32'h0000_00FF, 32'd31, FUNCT_FSHIFT, 4'h7, 32'h8000_007F, 34, 1};
        vecs[7] = '{32'h0000_0001, 32'd1,  FUNCT_FSHIFT, 4'h8, 32'h0000_0002, 4,  1};

        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_funct  = '0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_out_valid",  32'(io.out_valid),  32'd0);
        check("rst_out_result", io.out_result,      32'd0);
        check("rst_out_tag",    32'(io.out_tag),    32'd0);
        check("rst_sh_valid_i", 32'(sh_valid_i),    32'd0);
        check("rst_sh_a",       sh_a,               32'd0);
        check("rst_sh_b",       sh_b,               32'd0);
        check("rst_sh_funct",   32'(sh_funct),      32'd0);
        check("rst_busy",       32'(busy),          32'd0);
        check("rst_err",        32'(err),           32'd0);
        check("rst_in_ready",   32'(io.in_ready),   32'd1);

        for (int i = 0; i < 8; i++) run_one(vecs[i], i);

        // Funnel op followed by a plain shift: in-order results, second issue only after first result.
        res_q.delete(); rtag_q.delete(); iss_q.delete();
        acc = issue_cnt;
        push_op(32'h8000_0001, 32'd4, FUNCT_FSHIFT, 4'h5);
        push_op(32'h0000_0080, 32'd3, FUNCT_SHR,    4'h6);
        w = 0;
        while (res_q.size() < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("order_count", 32'(res_q.size()), 32'd2);
        if (res_q.size() >= 2) begin
            check("order_r0",   res_q[0],        32'h0000_0018);
            check("order_t0",   rtag_q[0],       32'h5);
            check("order_iss0", 32'(iss_q[0]),   32'(acc + 1));
            check("order_r1",   res_q[1],        32'h0000_0010);
            check("order_t1",   rtag_q[1],       32'h6);
            check("order_iss1", 32'(iss_q[1]),   32'(acc + 2));
        end

        // Back-pressure: queue plus result register absorb DEPTH+1 ops, then drain in order.
        res_q.delete(); rtag_q.delete(); iss_q.delete();
        io.out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (io.in_ready && acc < 8) begin
                io.in_valid = 1'b1;
                io.in_a     = 32'(acc + 1);
                io.in_b     = 32'd1;
                io.in_funct = FUNCT_SHL;
                io.in_tag   = 4'(acc);
                acc++;
            end else begin
                io.in_valid = 1'b0;
            end
        end
        check("fill_accepted",  32'(acc),          32'(DEPTH + 1));
        check("fill_in_ready",  32'(io.in_ready),  32'd0);
        check("fill_out_valid", 32'(io.out_valid), 32'd1);
        check("fill_busy",      32'(busy),         32'd1);
        io.out_ready = 1'b1;
        w = 0;
        while (res_q.size() < DEPTH + 1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_count", 32'(res_q.size()), 32'(DEPTH + 1));
        if (res_q.size() >= DEPTH + 1) begin
            for (int i = 0; i <= DEPTH; i++) begin
                check($sformatf("drain_r%0d", i), res_q[i],  32'((i + 1) * 2));
                check($sformatf("drain_t%0d", i), rtag_q[i], 32'(i));
            end
        end
        @(negedge clk);

        // Reset while waiting on the funnel shifter; the late model valid must be ignored.
        push_op(32'h0000_0001, 32'd10, FUNCT_FSHIFT, 4'h9);
        push_op(32'h0000_0003, 32'd1,  FUNCT_SHL,    4'h4);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ov = 1'b0;
        iv = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ov |= io.out_valid;
            iv |= sh_valid_i;
        end
        check("post_rst_out_valid", 32'(ov),           32'd0);
        check("post_rst_issue",     32'(iv),           32'd0);
        check("post_rst_busy",      32'(busy),         32'd0);
        check("post_rst_in_ready",  32'(io.in_ready),  32'd1);
        check("post_rst_result",    io.out_result,     32'd0);

`ifdef ALU_SHIFT_ISSUE_TIMEOUT_EN
        begin
            vec_t tv;
            m_hold = 1'b1;
            tv = '{32'h0000_0001, 32'd8, FUNCT_FSHIFT, 4'hA, 32'hDEAD_BEEF, TMO_CYC + 1, 1};
            run_one(tv, 99);
            check("tmo_err", 32'(err), 32'd1);
            m_hold = 1'b0;
        end
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
